// File: rtl/aes_result_writer.sv
// aes_result_writer: captures a 256-bit AES result on aes_done and streams it
// MSB byte first into an output SRAM, one byte per clock, then parks in DONE.
// Optional digest comparator: define AES_RESULT_CMP_EN to compare each written
// byte against sha3_o and drive auth_pass; otherwise auth_pass is tied to 0.
module aes_result_writer #(
  parameter int unsigned SRAM_DATA_BW = 8,
  parameter int unsigned SRAM_ADDR_BW = 5,
  parameter int unsigned AES_TXT_BW   = 128
) (
  input  logic                      clk,
  input  logic                      srst_n,
  input  logic                      mode,
  input  logic                      aes_done,
  input  logic [AES_TXT_BW-1:0]     aes_o_msb,
  input  logic [AES_TXT_BW-1:0]     aes_o_lsb,
  input  logic [2*AES_TXT_BW-1:0]   sha3_o,
  output logic                      out_sram_wen,
  output logic [SRAM_ADDR_BW-1:0]   out_sram_addr,
  output logic [SRAM_DATA_BW-1:0]   out_sram_data,
  output logic                      busy,
  output logic                      done,
  output logic                      auth_pass
);

  localparam int unsigned BUF_BW    = 2 * AES_TXT_BW;
  localparam int unsigned NUM_BYTES = BUF_BW / SRAM_DATA_BW;
  localparam logic [SRAM_ADDR_BW-1:0] LAST_ADDR = SRAM_ADDR_BW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [SRAM_ADDR_BW-1:0] cnt_q, cnt_d;
  logic [BUF_BW-1:0]       buf_q, buf_d;
  logic                    mode_q, mode_d;

  logic                    wen_q, wen_d;
  logic [SRAM_ADDR_BW-1:0] addr_q, addr_d;
  logic [SRAM_DATA_BW-1:0] data_q, data_d;
  logic                    done_q, done_d;

  // Next-state: capture only from IDLE, shift one byte per cycle in WRITE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (aes_done) begin
          state_d = WRITE;
          cnt_d   = '0;
          buf_d   = {aes_o_msb, aes_o_lsb};
          mode_d  = mode;
        end
      end
      WRITE: begin
        buf_d = buf_q << SRAM_DATA_BW;
        cnt_d = cnt_q + SRAM_ADDR_BW'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output next values derived from next state so outputs come straight from flops
  always_comb begin
    wen_d  = (state_d == WRITE);
    addr_d = '0;
    data_d = '0;
    if (wen_d) begin
      addr_d = cnt_d;
      data_d = buf_d[BUF_BW-1 -: SRAM_DATA_BW];
    end
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      mode_q  <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      mode_q  <= mode_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign out_sram_wen  = wen_q;
  assign out_sram_addr = addr_q;
  assign out_sram_data = data_q;
  assign busy          = wen_q;
  assign done          = done_q;

`ifdef AES_RESULT_CMP_EN
  logic [BUF_BW-1:0] sha3_sh;
  logic              mism_q, mism_d;
  logic              auth_q, auth_d;

  // Compare the byte being emitted with the same-position digest byte
  always_comb begin
    sha3_sh = sha3_o << (32'(cnt_q) * SRAM_DATA_BW);
    mism_d  = mism_q;
    if (state_q == IDLE && aes_done) begin
      mism_d = 1'b0;
    end else if (state_q == WRITE &&
                 buf_q[BUF_BW-1 -: SRAM_DATA_BW] != sha3_sh[BUF_BW-1 -: SRAM_DATA_BW]) begin
      mism_d = 1'b1;
    end
    auth_d = (state_d == DONE) && mode_q && !mism_d;
  end

  // Sticky mismatch flag and registered authentication result
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      mism_q <= 1'b0;
      auth_q <= 1'b0;
    end else begin
      mism_q <= mism_d;
      auth_q <= auth_d;
    end
  end

  assign auth_pass = auth_q;
`else
  // Digest and captured mode have no consumer without the comparator
  logic unused_cmp;
  assign unused_cmp = ^{sha3_o, mode_q};
  assign auth_pass  = 1'b0;
`endif

endmodule

// File: tb/tb_aes_result_writer.sv
// Directed bench for aes_result_writer; comparator checks follow AES_RESULT_CMP_EN.
module tb_aes_result_writer;

`ifdef AES_RESULT_CMP_EN
  localparam logic CMP = 1'b1;
`else
  localparam logic CMP = 1'b0;
`endif

  logic         clk;
  logic         srst_n;
  logic         mode;
  logic         aes_done;
  logic [127:0] aes_o_msb;
  logic [127:0] aes_o_lsb;
  logic [255:0] sha3_o;
  logic         out_sram_wen;
  logic [4:0]   out_sram_addr;
  logic [7:0]   out_sram_data;
  logic         busy;
  logic         done;
  logic         auth_pass;

  int tests = 0;
  int fails = 0;

  aes_result_writer dut (
    .clk           (clk),
    .srst_n        (srst_n),
    .mode          (mode),
    .aes_done      (aes_done),
    .aes_o_msb     (aes_o_msb),
    .aes_o_lsb     (aes_o_lsb),
    .sha3_o        (sha3_o),
    .out_sram_wen  (out_sram_wen),
    .out_sram_addr (out_sram_addr),
    .out_sram_data (out_sram_data),
    .busy          (busy),
    .done          (done),
    .auth_pass     (auth_pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 32-byte vector whose byte i (MSB first) is base+i
  function automatic logic [255:0] pattern(input logic [7:0] base);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v[255 - 8*i -: 8] = base + 8'(i);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag, input logic exp_done);
    check({tag, " wen"},  32'(out_sram_wen),  0);
    check({tag, " addr"}, 32'(out_sram_addr), 0);
    check({tag, " data"}, 32'(out_sram_data), 0);
    check({tag, " busy"}, 32'(busy),          0);
    check({tag, " done"}, 32'(done),          32'(exp_done));
  endtask

  task automatic do_reset();
    @(negedge clk);
    srst_n = 1'b0;
    #1;
    check_quiet("reset", 1'b0);
    check("reset auth", 32'(auth_pass), 0);
    @(negedge clk);
    srst_n = 1'b1;
  endtask

  // One transfer; optional re-trigger or reset abort at a given write index
  task automatic run_txn(input logic [7:0] base, input logic m, input logic [255:0] sha,
                         input int retrig_at, input int abort_at, input logic exp_auth);
    @(negedge clk);
    aes_done = 1'b1;
    mode     = m;
    {aes_o_msb, aes_o_lsb} = pattern(base);
    sha3_o   = sha;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      aes_done = 1'b0;
      check($sformatf("wen[%0d]", i),   32'(out_sram_wen),  1);
      check($sformatf("waddr[%0d]", i), 32'(out_sram_addr), 32'(i));
      check($sformatf("wdata[%0d]", i), 32'(out_sram_data), 32'(8'(base + 8'(i))));
      check($sformatf("busy[%0d]", i),  32'(busy),          1);
      check($sformatf("done[%0d]", i),  32'(done),          0);
      check($sformatf("auth[%0d]", i),  32'(auth_pass),     0);
      if (i == retrig_at) begin
        aes_done = 1'b1;
        mode     = ~m;
        {aes_o_msb, aes_o_lsb} = pattern(8'hC0);
      end
      if (i == abort_at) begin
        srst_n = 1'b0;
        #1;
        check_quiet("abort", 1'b0);
        check("abort auth", 32'(auth_pass), 0);
        @(negedge clk);
        srst_n = 1'b1;
        repeat (4) begin
          @(negedge clk);
          check_quiet("post-abort", 1'b0);
        end
        return;
      end
    end
    @(negedge clk);
    check_quiet("end", 1'b1);
    check("end auth", 32'(auth_pass), 32'(exp_auth));
    aes_done = 1'b1;
    {aes_o_msb, aes_o_lsb} = pattern(8'h55);
    repeat (3) begin
      @(negedge clk);
      aes_done = 1'b0;
      check_quiet("sticky", 1'b1);
      check("sticky auth", 32'(auth_pass), 32'(exp_auth));
    end
  endtask

  initial begin
    srst_n    = 1'b0;
    mode      = 1'b0;
    aes_done  = 1'b0;
    aes_o_msb = '0;
    aes_o_lsb = '0;
    sha3_o    = '0;
    #2;
    check_quiet("por", 1'b0);
    check("por auth", 32'(auth_pass), 0);
    @(negedge clk);
    srst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_quiet("idle", 1'b0);
    end

    // Basic stream 0x00..0x1F, encrypt mode
    run_txn(8'h00, 1'b0, pattern(8'h00), -1, -1, 1'b0);

    // Re-trigger mid-write ignored; decrypt with matching digest
    do_reset();
    run_txn(8'h80, 1'b1, pattern(8'h80), 10, -1, CMP);

    // Reset at write 15 aborts, then a fresh transfer from IDLE with byte 31 flipped
    do_reset();
    run_txn(8'h20, 1'b0, pattern(8'h20), -1, 15, 1'b0);
    run_txn(8'h40, 1'b1, pattern(8'h40) ^ 256'h1, -1, -1, 1'b0);

    // Encrypt mode never authenticates even with matching digest
    do_reset();
    run_txn(8'h60, 1'b0, pattern(8'h60), -1, -1, 1'b0);

    // Mismatch on the first byte
    do_reset();
    run_txn(8'h10, 1'b1, pattern(8'h10) ^ {8'h01, 248'h0}, -1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
